regfile_sb: RTL and testbench

//  Operand-fetch stage directly upstream of the ALU. Holds the 8x16 LC-3b register file and a scoreboard of

---
 rtl/regfile_sb_pkg.sv | 23 ++
 rtl/regfile_sb_if.sv | 49 ++++
 rtl/regfile_sb_scoreboard.sv | 64 ++++++
 rtl/regfile_sb.sv | 107 ++++++++++
 tb/tb_regfile_sb.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_pkg
// Description : Shared LC-3b word/register types and operand-slot FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_sb_pkg;

    localparam int c_WORD_W   = 16;
    localparam int c_NUM_REGS = 8;
    localparam int c_REG_W    = $clog2(c_NUM_REGS);

    typedef logic [c_WORD_W-1:0]   lc3b_word;
    typedef logic [c_REG_W-1:0]    lc3b_reg;
    typedef logic [c_NUM_REGS-1:0] lc3b_pending;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_if
// Description : Issue, operand and writeback bus of the operand-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic             iss_valid;
    logic             iss_ready;
    logic [IDX_W-1:0] iss_sr1;
    logic [IDX_W-1:0] iss_sr2;
    logic             iss_use2;
    logic [WIDTH-1:0] iss_imm;
    logic [IDX_W-1:0] iss_dest;
    logic             iss_wr;

    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [IDX_W-1:0] op_dest;
    logic             op_wr;

    logic             wb_valid;
    logic [IDX_W-1:0] wb_reg;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output iss_valid, iss_sr1, iss_sr2, iss_use2, iss_imm, iss_dest, iss_wr,
        input  iss_ready,
        input  op_valid, op_a, op_b, op_dest, op_wr,
        output op_ready,
        output wb_valid, wb_reg, wb_data
    );

    modport slave (
        input  iss_valid, iss_sr1, iss_sr2, iss_use2, iss_imm, iss_dest, iss_wr,
        output iss_ready,
        output op_valid, op_a, op_b, op_dest, op_wr,
        input  op_ready,
        input  wb_valid, wb_reg, wb_data
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Pending-write bits with RAW/WAW hazard detection.
//               REGFILE_SB_BYPASS_EN: same-cycle writeback resolves a hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NUM_REGS = c_NUM_REGS,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_set_en,
    input  wire logic [IDX_W-1:0] i_set_reg,
    input  wire logic             i_clr_en,
    input  wire logic [IDX_W-1:0] i_clr_reg,
    input  wire logic [IDX_W-1:0] i_sr1,
    input  wire logic [IDX_W-1:0] i_sr2,
    input  wire logic             i_use2,
    input  wire logic [IDX_W-1:0] i_dest,
    input  wire logic             i_wr,
    output logic                  o_hazard,
    output logic                  o_byp_a,
    output logic                  o_byp_b
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic [NUM_REGS-1:0] w_pending_eff;

    // Set is applied after clear so an issue re-claiming a register wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr_en) w_pending_nxt[i_clr_reg] = 1'b0;
        if (i_set_en) w_pending_nxt[i_set_reg] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pending <= '0;
        else     r_pending <= w_pending_nxt;
    end

`ifdef REGFILE_SB_BYPASS_EN
    always_comb begin
        w_pending_eff = r_pending;
        if (i_clr_en) w_pending_eff[i_clr_reg] = 1'b0;
    end
    assign o_byp_a = i_clr_en && (i_clr_reg == i_sr1);
    assign o_byp_b = i_clr_en && (i_clr_reg == i_sr2);
`else
    assign w_pending_eff = r_pending;
    assign o_byp_a       = 1'b0;
    assign o_byp_b       = 1'b0;
`endif

    assign o_hazard = w_pending_eff[i_sr1]
                    | (i_use2 & w_pending_eff[i_sr2])
                    | (i_wr   & w_pending_eff[i_dest]);

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : LC-3b operand-fetch stage: register file, scoreboard and a
//               registered operand slot. Option macro: REGFILE_SB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH    = c_WORD_W,
    parameter int NUM_REGS = c_NUM_REGS
) (
    input  wire logic   clk,
    input  wire logic   rst,
    regfile_sb_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [WIDTH-1:0] r_rf [NUM_REGS];
    slot_state_e      r_state;
    slot_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [IDX_W-1:0] r_op_dest;
    logic             r_op_wr;

    logic             w_hazard;
    logic             w_byp_a;
    logic             w_byp_b;
    logic             w_accept;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_set_en  (w_accept && bus.iss_wr),
        .i_set_reg (bus.iss_dest),
        .i_clr_en  (bus.wb_valid),
        .i_clr_reg (bus.wb_reg),
        .i_sr1     (bus.iss_sr1),
        .i_sr2     (bus.iss_sr2),
        .i_use2    (bus.iss_use2),
        .i_dest    (bus.iss_dest),
        .i_wr      (bus.iss_wr),
        .o_hazard  (w_hazard),
        .o_byp_a   (w_byp_a),
        .o_byp_b   (w_byp_b)
    );

    assign bus.iss_ready = !w_hazard && ((r_state == SLOT_EMPTY) || bus.op_ready);
    assign w_accept      = bus.iss_valid && bus.iss_ready;

    assign w_rd_a = w_byp_a ? bus.wb_data : r_rf[bus.iss_sr1];
    assign w_rd_b = !bus.iss_use2 ? bus.iss_imm
                  : (w_byp_b ? bus.wb_data : r_rf[bus.iss_sr2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
        end else if (bus.wb_valid) begin
            r_rf[bus.wb_reg] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= SLOT_EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (w_accept) w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (bus.op_ready && !w_accept) w_state_nxt = SLOT_EMPTY;
            default:    w_state_nxt = SLOT_EMPTY;
        endcase
    end

    // Operands only load on accept, which keeps them stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_dest <= '0;
            r_op_wr   <= 1'b0;
        end else if (w_accept) begin
            r_op_a    <= w_rd_a;
            r_op_b    <= w_rd_b;
            r_op_dest <= bus.iss_dest;
            r_op_wr   <= bus.iss_wr;
        end
    end

    assign bus.op_valid = (r_state == SLOT_FULL);
    assign bus.op_a     = r_op_a;
    assign bus.op_b     = r_op_b;
    assign bus.op_dest  = r_op_dest;
    assign bus.op_wr    = r_op_wr;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed self-checking bench for regfile_sb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

`ifdef REGFILE_SB_BYPASS_EN
    localparam logic c_BYP = 1'b1;
`else
    localparam logic c_BYP = 1'b0;
`endif

    logic [2:0]  b2b_reg [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
    logic [15:0] b2b_exp [4] = '{16'h0011, 16'h00FF, 16'h1234, 16'h5555};

    regfile_sb_if #(.WIDTH(16), .NUM_REGS(8)) bus ();

    regfile_sb #(.WIDTH(16), .NUM_REGS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] sr1, input logic [2:0] sr2, input logic use2,
                         input logic [15:0] imm, input logic [2:0] dest, input logic wr);
        bus.iss_valid = 1'b1;
        bus.iss_sr1   = sr1;
        bus.iss_sr2   = sr2;
        bus.iss_use2  = use2;
        bus.iss_imm   = imm;
        bus.iss_dest  = dest;
        bus.iss_wr    = wr;
    endtask

    task automatic wb(input logic [2:0] r, input logic [15:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_reg   = r;
        bus.wb_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.iss_valid = 1'b0; bus.iss_sr1 = '0; bus.iss_sr2 = '0; bus.iss_use2 = 1'b0;
        bus.iss_imm = '0; bus.iss_dest = '0; bus.iss_wr = 1'b0;
        bus.op_ready = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
        chk("rst_op_a",     32'(bus.op_a),     32'd0);
        chk("rst_op_b",     32'(bus.op_b),     32'd0);
        chk("rst_op_dest",  32'(bus.op_dest),  32'd0);
        chk("rst_op_wr",    32'(bus.op_wr),    32'd0);
        chk("rst_iss_ready", 32'(bus.iss_ready), 32'd1);

        // Writeback R3 then read it through both ports
        tick();
        wb(3'd3, 16'h1234);
        tick();
        bus.wb_valid = 1'b0;
        issue(3'd3, 3'd3, 1'b1, 16'h0, 3'd0, 1'b0);
        #1 chk("rd_ready", 32'(bus.iss_ready), 32'd1);
        tick();
        bus.iss_valid = 1'b0;
        chk("rd_op_valid", 32'(bus.op_valid), 32'd1);
        chk("rd_op_a", 32'(bus.op_a), 32'h1234);
        chk("rd_op_b", 32'(bus.op_b), 32'h1234);
        bus.op_ready = 1'b1;
        tick();
        chk("rd_drain", 32'(bus.op_valid), 32'd0);

        // RAW hazard on R2
        issue(3'd0, 3'd0, 1'b1, 16'h0, 3'd2, 1'b1);
        tick();
        chk("raw_op_dest", 32'(bus.op_dest), 32'd2);
        chk("raw_op_wr",   32'(bus.op_wr),   32'd1);
        issue(3'd2, 3'd0, 1'b0, 16'h0, 3'd0, 1'b0);
        #1 chk("raw_stall1", 32'(bus.iss_ready), 32'd0);
        tick();
        #1 chk("raw_stall2", 32'(bus.iss_ready), 32'd0);
        chk("raw_bubble", 32'(bus.op_valid), 32'd0);
        wb(3'd2, 16'h00FF);
        #1 chk("raw_wb_cycle_ready", 32'(bus.iss_ready), 32'(c_BYP));
        tick();
        bus.wb_valid = 1'b0;
`ifndef REGFILE_SB_BYPASS_EN
        #1 chk("raw_after_wb_ready", 32'(bus.iss_ready), 32'd1);
        tick();
`endif
        bus.iss_valid = 1'b0;
        chk("raw_op_valid", 32'(bus.op_valid), 32'd1);
        chk("raw_op_a", 32'(bus.op_a), 32'h00FF);
        tick();

        // Same-cycle set and clear of R6: set wins
        issue(3'd0, 3'd0, 1'b1, 16'h0, 3'd6, 1'b1);
        wb(3'd6, 16'h6666);
        #1 chk("setclr_ready", 32'(bus.iss_ready), 32'd1);
        tick();
        bus.wb_valid = 1'b0;
        issue(3'd6, 3'd0, 1'b0, 16'h0, 3'd0, 1'b0);
        #1 chk("set_wins", 32'(bus.iss_ready), 32'd0);
        wb(3'd6, 16'h6666);
        tick();
        bus.wb_valid = 1'b0;
        tick();
        bus.iss_valid = 1'b0;
        chk("setclr_op_valid", 32'(bus.op_valid), 32'd1);
        chk("setclr_op_a", 32'(bus.op_a), 32'h6666);
        tick();

        // Immediate operand bypasses a pending sr2
        issue(3'd0, 3'd0, 1'b1, 16'h0, 3'd5, 1'b1);
        tick();
        issue(3'd3, 3'd5, 1'b1, 16'h001F, 3'd0, 1'b0);
        #1 chk("use2_hazard", 32'(bus.iss_ready), 32'd0);
        bus.iss_use2 = 1'b0;
        #1 chk("imm_nostall", 32'(bus.iss_ready), 32'd1);
        tick();
        bus.iss_valid = 1'b0;
        chk("imm_op_a", 32'(bus.op_a), 32'h1234);
        chk("imm_op_b", 32'(bus.op_b), 32'h001F);
        wb(3'd5, 16'h5555);
        tick();
        bus.wb_valid = 1'b0;

        // Backpressure: operands held while op_ready low
        wb(3'd1, 16'h0011);
        tick();
        bus.wb_valid = 1'b0;
        bus.op_ready = 1'b0;
        issue(3'd1, 3'd3, 1'b1, 16'h0, 3'd4, 1'b0);
        tick();
        issue(3'd3, 3'd1, 1'b1, 16'h0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", 32'(bus.iss_ready), 32'd0);
            chk("hold_valid", 32'(bus.op_valid), 32'd1);
            chk("hold_op_a",  32'(bus.op_a), 32'h0011);
            chk("hold_op_b",  32'(bus.op_b), 32'h1234);
            tick();
        end
        bus.op_ready = 1'b1;
        #1 chk("release_ready", 32'(bus.iss_ready), 32'd1);
        tick();
        bus.iss_valid = 1'b0;
        chk("release_valid", 32'(bus.op_valid), 32'd1);
        chk("release_op_a", 32'(bus.op_a), 32'h1234);
        chk("release_op_b", 32'(bus.op_b), 32'h0011);
        tick();
        chk("release_drain", 32'(bus.op_valid), 32'd0);

        // Back-to-back independent issues
        for (int k = 0; k < 4; k++) begin
            issue(b2b_reg[k], 3'd0, 1'b0, 16'(k), 3'd0, 1'b0);
            tick();
            chk("b2b_valid", 32'(bus.op_valid), 32'd1);
            chk("b2b_op_a", 32'(bus.op_a), 32'(b2b_exp[k]));
            chk("b2b_op_b", 32'(bus.op_b), 32'(k));
        end
        bus.iss_valid = 1'b0;
        tick();
        chk("b2b_drain", 32'(bus.op_valid), 32'd0);

        // Reset in the middle of traffic
        bus.op_ready = 1'b0;
        issue(3'd3, 3'd3, 1'b1, 16'h0, 3'd7, 1'b1);
        tick();
        bus.iss_valid = 1'b0;
        chk("mid_valid", 32'(bus.op_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.op_valid), 32'd0);
        chk("mid_rst_op_a", 32'(bus.op_a), 32'd0);
        tick();
        rst = 1'b0;
        bus.op_ready = 1'b1;
        issue(3'd7, 3'd7, 1'b1, 16'h0, 3'd7, 1'b0);
        #1 chk("mid_rst_ready", 32'(bus.iss_ready), 32'd1);
        for (int r = 0; r < 8; r++) begin
            issue(3'(r), 3'(r), 1'b1, 16'hFFFF, 3'd0, 1'b0);
            tick();
            chk("mid_rst_reg_a", 32'(bus.op_a), 32'd0);
            chk("mid_rst_reg_b", 32'(bus.op_b), 32'd0);
        end
        bus.iss_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
